// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: zero-latency Mealy recogniser for a programmable LEN-symbol pattern
// Ports: clock/reset_ (async, active low); x/dav symbol stream; overlap mode;
//        clear sync flush; z same-cycle match flag; count saturating matches;
//        fill number of valid history symbols.
// Optional: define SEQ_DETECT_TIMEOUT_EN to abandon partial patterns after TIMEOUT idle cycles.
module mealy_seq_detector #(
    parameter int W = 2,
    parameter int LEN = 3,
    parameter logic [LEN*W-1:0] PATTERN = {2'd1, 2'd2, 2'd3},
    parameter int CW = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    reset_,
    input  logic [W-1:0]            x,
    input  logic                    dav,
    input  logic                    overlap,
    input  logic                    clear,
    output logic                    z,
    output logic [CW-1:0]           count,
    output logic [$clog2(LEN)-1:0]  fill
);
    localparam int FW = $clog2(LEN);
    localparam int HW = (LEN - 1) * W;
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);

    if (LEN < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("mealy_seq_detector: LEN must be >= 2 and TIMEOUT in 1..255");
    end

    logic [HW-1:0]   hist, hist_n;
    logic [FW-1:0]   fill_n;
    logic [CW-1:0]   count_n, count_inc;
    logic [HW+W-1:0] cat;
`ifdef SEQ_DETECT_TIMEOUT_EN
    logic [7:0]      idle, idle_n;
    logic            expire;
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            hist  <= '0;
            fill  <= '0;
            count <= '0;
`ifdef SEQ_DETECT_TIMEOUT_EN
            idle  <= '0;
`endif
        end else begin
            hist  <= hist_n;
            fill  <= fill_n;
            count <= count_n;
`ifdef SEQ_DETECT_TIMEOUT_EN
            idle  <= idle_n;
`endif
        end
    end

    always_comb begin
        cat       = {hist, x};
        count_inc = &count ? count : count + 1'b1;
        hist_n    = hist;
        fill_n    = fill;
        count_n   = count;
`ifdef SEQ_DETECT_TIMEOUT_EN
        // Flush lands on the edge that would make the idle count reach TIMEOUT.
        expire    = !dav && !clear && idle == 8'(TIMEOUT - 1);
        idle_n    = (dav || clear || expire) ? 8'd0 : idle + 8'd1;
`endif
        if (clear) begin
            hist_n  = '0;
            fill_n  = '0;
            count_n = '0;
        end else if (dav && z) begin
            hist_n  = overlap ? cat[HW-1:0] : '0;
            fill_n  = overlap ? FULL : '0;
            count_n = count_inc;
        end else if (dav) begin
            hist_n  = cat[HW-1:0];
            fill_n  = fill == FULL ? FULL : fill + 1'b1;
        end
`ifdef SEQ_DETECT_TIMEOUT_EN
        else if (expire) begin
            hist_n  = '0;
            fill_n  = '0;
        end
`endif
    end

    always_comb z = dav && !clear && fill == FULL && {hist, x} == PATTERN;
endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb_mealy_seq_detector: directed self-checking bench for mealy_seq_detector
module tb_mealy_seq_detector;
    logic clock = 1'b0;
    logic reset_ = 1'b0;
    logic [1:0] x = '0;
    logic dav = 1'b0;
    logic overlap = 1'b1;
    logic clear = 1'b0;
    int checks = 0;
    int errors = 0;

    logic z0, z1, z2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [1:0] f0, f1, f2;

    always #5 clock = ~clock;

    mealy_seq_detector d0 (.clock(clock), .reset_(reset_), .x(x), .dav(dav), .overlap(overlap),
                           .clear(clear), .z(z0), .count(c0), .fill(f0));
    mealy_seq_detector #(.PATTERN(6'b01_01_01)) d1 (.clock(clock), .reset_(reset_), .x(x), .dav(dav),
                           .overlap(overlap), .clear(clear), .z(z1), .count(c1), .fill(f1));
    mealy_seq_detector #(.CW(2)) d2 (.clock(clock), .reset_(reset_), .x(x), .dav(dav), .overlap(overlap),
                           .clear(clear), .z(z2), .count(c2), .fill(f2));
`ifdef SEQ_DETECT_TIMEOUT_EN
    logic z3;
    logic [7:0] c3;
    logic [1:0] f3;
    mealy_seq_detector #(.TIMEOUT(4)) d3 (.clock(clock), .reset_(reset_), .x(x), .dav(dav),
                           .overlap(overlap), .clear(clear), .z(z3), .count(c3), .fill(f3));
`endif

    task automatic apply(input logic [1:0] xv, input logic dv);
        @(negedge clock);
        x = xv;
        dav = dv;
        #1;
    endtask

    task automatic flush();
        @(negedge clock);
        clear = 1'b1;
        dav = 1'b0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks += 3;
        if (z0 !== 1'b0) begin errors++; $display("FAIL reset_z got %b want 0", z0); end
        if (c0 !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", c0); end
        if (f0 !== 2'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", f0); end
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] xs [3] = '{2'd1, 2'd2, 2'd3};
        logic zs [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0] fs [3] = '{2'd0, 2'd1, 2'd2};
        overlap = 1'b1;
        flush();
        for (int i = 0; i < 3; i++) begin
            apply(xs[i], 1'b1);
            checks += 2;
            if (z0 !== zs[i]) begin errors++; $display("FAIL basic_z[%0d] got %b want %b", i, z0, zs[i]); end
            if (f0 !== fs[i]) begin errors++; $display("FAIL basic_fill[%0d] got %0d want %0d", i, f0, fs[i]); end
        end
        checks++;
        if (c0 !== 8'd0) begin errors++; $display("FAIL basic_count_early got %0d want 0", c0); end
        apply(2'd0, 1'b0);
        checks += 3;
        if (c0 !== 8'd1) begin errors++; $display("FAIL basic_count got %0d want 1", c0); end
        if (f0 !== 2'd2) begin errors++; $display("FAIL basic_fill_after got %0d want 2", f0); end
        if (z0 !== 1'b0) begin errors++; $display("FAIL basic_z_idle got %b want 0", z0); end
    endtask

    task automatic test_overlap();
        logic zo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic zn [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        overlap = 1'b1;
        flush();
        for (int i = 0; i < 6; i++) begin
            apply(2'd1, 1'b1);
            checks++;
            if (z1 !== zo[i]) begin errors++; $display("FAIL ovl_z[%0d] got %b want %b", i, z1, zo[i]); end
        end
        apply(2'd0, 1'b0);
        checks++;
        if (c1 !== 8'd4) begin errors++; $display("FAIL ovl_count got %0d want 4", c1); end
        overlap = 1'b0;
        flush();
        for (int i = 0; i < 6; i++) begin
            apply(2'd1, 1'b1);
            checks++;
            if (z1 !== zn[i]) begin errors++; $display("FAIL novl_z[%0d] got %b want %b", i, z1, zn[i]); end
        end
        apply(2'd0, 1'b0);
        checks++;
        if (c1 !== 8'd2) begin errors++; $display("FAIL novl_count got %0d want 2", c1); end
    endtask

    task automatic test_idle();
        overlap = 1'b1;
        flush();
        apply(2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(2'd3, 1'b0);
            checks++;
            if (z0 !== 1'b0) begin errors++; $display("FAIL idle_z[%0d] got %b want 0", i, z0); end
        end
        apply(2'd2, 1'b1);
        apply(2'd3, 1'b0);
        checks++;
        if (z0 !== 1'b0) begin errors++; $display("FAIL idle_z_gap got %b want 0", z0); end
        apply(2'd3, 1'b1);
        checks++;
        if (z0 !== 1'b1) begin errors++; $display("FAIL idle_match got %b want 1", z0); end
        apply(2'd0, 1'b0);
        checks++;
        if (c0 !== 8'd1) begin errors++; $display("FAIL idle_count got %0d want 1", c0); end
    endtask

    task automatic test_saturate();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        overlap = 1'b0;
        flush();
        for (int k = 0; k < 5; k++) begin
            apply(2'd1, 1'b1);
            apply(2'd2, 1'b1);
            apply(2'd3, 1'b1);
            apply(2'd0, 1'b0);
            checks++;
            if (c2 !== want[k]) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", k, c2, want[k]); end
        end
    endtask

    task automatic test_async_reset();
        overlap = 1'b1;
        flush();
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        apply(2'd3, 1'b1);
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        @(posedge clock);
        #2;
        x = 2'd3;
        dav = 1'b1;
        #1;
        checks += 3;
        if (z0 !== 1'b1) begin errors++; $display("FAIL arst_pre_z got %b want 1", z0); end
        if (c0 !== 8'd1) begin errors++; $display("FAIL arst_pre_count got %0d want 1", c0); end
        if (f0 !== 2'd2) begin errors++; $display("FAIL arst_pre_fill got %0d want 2", f0); end
        reset_ = 1'b0;
        #1;
        checks += 3;
        if (z0 !== 1'b0) begin errors++; $display("FAIL arst_z got %b want 0", z0); end
        if (c0 !== 8'd0) begin errors++; $display("FAIL arst_count got %0d want 0", c0); end
        if (f0 !== 2'd0) begin errors++; $display("FAIL arst_fill got %0d want 0", f0); end
        @(negedge clock);
        dav = 1'b0;
        reset_ = 1'b1;
        apply(2'd3, 1'b1);
        checks++;
        if (z0 !== 1'b0) begin errors++; $display("FAIL arst_lone3 got %b want 0", z0); end
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        apply(2'd3, 1'b1);
        checks++;
        if (z0 !== 1'b1) begin errors++; $display("FAIL arst_rematch got %b want 1", z0); end
    endtask

    task automatic test_clear();
        overlap = 1'b1;
        flush();
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        apply(2'd3, 1'b1);
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        @(negedge clock);
        clear = 1'b1;
        dav = 1'b1;
        x = 2'd3;
        #1;
        checks += 2;
        if (z0 !== 1'b0) begin errors++; $display("FAIL clr_z got %b want 0", z0); end
        if (c0 !== 8'd1) begin errors++; $display("FAIL clr_pre_count got %0d want 1", c0); end
        @(negedge clock);
        clear = 1'b0;
        dav = 1'b0;
        #1;
        checks += 2;
        if (f0 !== 2'd0) begin errors++; $display("FAIL clr_fill got %0d want 0", f0); end
        if (c0 !== 8'd0) begin errors++; $display("FAIL clr_count got %0d want 0", c0); end
    endtask

`ifdef SEQ_DETECT_TIMEOUT_EN
    task automatic test_timeout();
        overlap = 1'b1;
        flush();
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        for (int i = 0; i < 4; i++) apply(2'd0, 1'b0);
        apply(2'd3, 1'b1);
        checks += 2;
        if (z3 !== 1'b0) begin errors++; $display("FAIL tmo4_z got %b want 0", z3); end
        if (f3 !== 2'd0) begin errors++; $display("FAIL tmo4_fill got %0d want 0", f3); end
        flush();
        apply(2'd1, 1'b1);
        apply(2'd2, 1'b1);
        for (int i = 0; i < 3; i++) apply(2'd0, 1'b0);
        apply(2'd3, 1'b1);
        checks++;
        if (z3 !== 1'b1) begin errors++; $display("FAIL tmo3_z got %b want 1", z3); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_idle();
        test_saturate();
        test_async_reset();
        test_clear();
`ifdef SEQ_DETECT_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
